// File: rtl/sram_arbiter_rr_if.sv
// Request/response and SRAM command bundle for the round-robin SRAM arbiter.
// The arbiter takes the slave view; whatever drives the ports and models the SRAM takes the master view.
interface sram_arbiter_rr_if #(
    parameter int NUM_W  = 2,
    parameter int NUM_R  = 2,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
);
    logic [NUM_W-1:0]        w_valid;
    logic [NUM_W-1:0]        w_ready;
    logic [NUM_W*ADDR_W-1:0] w_addr;
    logic [NUM_W*DATA_W-1:0] w_data;
    logic [NUM_W*MASK_W-1:0] w_mask;
    logic [NUM_R-1:0]        r_req_valid;
    logic [NUM_R-1:0]        r_req_ready;
    logic [NUM_R*ADDR_W-1:0] r_addr;
    logic [NUM_R-1:0]        r_resp_valid;
    logic [NUM_R-1:0]        r_resp_ready;
    logic [NUM_R*DATA_W-1:0] r_resp_data;
    logic                    sram_ready;
    logic                    sram_addr_valid;
    logic [ADDR_W-1:0]       sram_addr;
    logic [DATA_W-1:0]       sram_data_in;
    logic [MASK_W-1:0]       sram_write_mask;
    logic [DATA_W-1:0]       sram_data_out;
    logic                    sram_data_out_valid;
    logic                    err;

    modport slave (
        input  w_valid, w_addr, w_data, w_mask, r_req_valid, r_addr, r_resp_ready,
               sram_ready, sram_data_out, sram_data_out_valid,
        output w_ready, r_req_ready, r_resp_valid, r_resp_data,
               sram_addr_valid, sram_addr, sram_data_in, sram_write_mask, err
    );

    modport master (
        output w_valid, w_addr, w_data, w_mask, r_req_valid, r_addr, r_resp_ready,
               sram_ready, sram_data_out, sram_data_out_valid,
        input  w_ready, r_req_ready, r_resp_valid, r_resp_data,
               sram_addr_valid, sram_addr, sram_data_in, sram_write_mask, err
    );
endinterface

// File: rtl/sram_arbiter_rr.sv
// Round-robin arbiter sharing one SRAM command port among write and read ports.
// Read data returns through a fixed-latency tag pipeline into credit-protected per-port buffers.
module sram_arbiter_rr #(
    parameter int NUM_W      = 2,
    parameter int NUM_R      = 2,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 32,
    parameter int MASK_W     = 4,
    parameter int RD_LATENCY = 3,
    parameter int RBUF_DEPTH = 4
) (
    input logic sram_clock,
    input logic reset,
    sram_arbiter_rr_if.slave i_bus
);
    localparam int N     = NUM_W + NUM_R;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int RP_W  = (NUM_R > 1) ? $clog2(NUM_R) : 1;
    localparam int CR_W  = $clog2(RBUF_DEPTH + 1);
    localparam int PTR_W = $clog2(RBUF_DEPTH);
    localparam int Q_W   = $clog2(RD_LATENCY + 1);

    logic [IDX_W-1:0]  r_rrPtr;
    logic [CR_W-1:0]   r_credit [NUM_R];
    logic [CR_W-1:0]   r_count  [NUM_R];
    logic [PTR_W-1:0]  r_wrPtr  [NUM_R];
    logic [PTR_W-1:0]  r_rdPtr  [NUM_R];
    logic [DATA_W-1:0] r_buf    [NUM_R][RBUF_DEPTH];
    logic              r_tagValid [RD_LATENCY];
    logic [RP_W-1:0]   r_tagPort  [RD_LATENCY];
    logic [Q_W-1:0]    r_quietCnt;
    logic              r_err;

    logic [N-1:0]      w_eligible;
    logic              w_grant;
    logic [IDX_W-1:0]  w_grantIdx;
    logic [IDX_W-1:0]  w_idxBits;
    int                w_idx;
    logic [NUM_R-1:0]  w_rdGrant;
    logic [RP_W-1:0]   w_rdPort;
    logic              w_finalValid;
    logic [RP_W-1:0]   w_finalPort;
    logic              w_quiet;
    logic              w_spurious;
    logic [NUM_R-1:0]  w_push;
    logic [NUM_R-1:0]  w_pop;
    logic [NUM_R-1:0]  w_lost;

    // A read may only issue while its buffer has a slot not already promised to an in-flight read.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_W; i++)
            w_eligible[i] = i_bus.w_valid[i];
        for (int j = 0; j < NUM_R; j++)
            w_eligible[NUM_W + j] = i_bus.r_req_valid[j] && (r_credit[j] < CR_W'(RBUF_DEPTH));
    end

    always_comb begin
        w_grant    = 1'b0;
        w_grantIdx = '0;
        w_idx      = 0;
        w_idxBits  = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(r_rrPtr) + k;
            if (w_idx >= N)
                w_idx = w_idx - N;
            w_idxBits = IDX_W'(w_idx);
            if (!w_grant && w_eligible[w_idxBits] && i_bus.sram_ready && !reset) begin
                w_grant    = 1'b1;
                w_grantIdx = w_idxBits;
            end
        end
    end

    always_comb begin
        i_bus.w_ready         = '0;
        i_bus.r_req_ready     = '0;
        i_bus.sram_addr_valid = w_grant;
        i_bus.sram_addr       = '0;
        i_bus.sram_data_in    = '0;
        i_bus.sram_write_mask = '0;
        w_rdGrant             = '0;
        w_rdPort              = '0;
        for (int i = 0; i < NUM_W; i++) begin
            if (w_grant && int'(w_grantIdx) == i) begin
                i_bus.w_ready[i]      = 1'b1;
                i_bus.sram_addr       = i_bus.w_addr[i*ADDR_W +: ADDR_W];
                i_bus.sram_data_in    = i_bus.w_data[i*DATA_W +: DATA_W];
                i_bus.sram_write_mask = i_bus.w_mask[i*MASK_W +: MASK_W];
            end
        end
        for (int j = 0; j < NUM_R; j++) begin
            if (w_grant && int'(w_grantIdx) == NUM_W + j) begin
                i_bus.r_req_ready[j] = 1'b1;
                i_bus.sram_addr      = i_bus.r_addr[j*ADDR_W +: ADDR_W];
                w_rdGrant[j]         = 1'b1;
                w_rdPort             = RP_W'(j);
            end
        end
    end

    assign w_finalValid = r_tagValid[RD_LATENCY-1];
    assign w_finalPort  = r_tagPort[RD_LATENCY-1];
    assign w_quiet      = (r_quietCnt != '0);
    assign w_spurious   = i_bus.sram_data_out_valid && !w_finalValid && !w_quiet;

    // A missing return still releases its credit so the port cannot lock up.
    always_comb begin
        w_push = '0;
        w_pop  = '0;
        w_lost = '0;
        i_bus.r_resp_valid = '0;
        i_bus.r_resp_data  = '0;
        for (int j = 0; j < NUM_R; j++) begin
            w_push[j] = w_finalValid && i_bus.sram_data_out_valid && (w_finalPort == RP_W'(j));
            w_lost[j] = w_finalValid && !i_bus.sram_data_out_valid && (w_finalPort == RP_W'(j));
            w_pop[j]  = (r_count[j] != '0) && i_bus.r_resp_ready[j];
            i_bus.r_resp_valid[j] = (r_count[j] != '0);
            if (r_count[j] != '0)
                i_bus.r_resp_data[j*DATA_W +: DATA_W] = r_buf[j][r_rdPtr[j]];
        end
    end

    assign i_bus.err = r_err;

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            r_rrPtr    <= '0;
            r_err      <= 1'b0;
            r_quietCnt <= Q_W'(RD_LATENCY);
            for (int s = 0; s < RD_LATENCY; s++) begin
                r_tagValid[s] <= 1'b0;
                r_tagPort[s]  <= '0;
            end
            for (int j = 0; j < NUM_R; j++) begin
                r_credit[j] <= '0;
                r_count[j]  <= '0;
                r_wrPtr[j]  <= '0;
                r_rdPtr[j]  <= '0;
            end
        end else begin
            if (w_grant)
                r_rrPtr <= (int'(w_grantIdx) == N - 1) ? '0 : w_grantIdx + IDX_W'(1);
            if (w_quiet)
                r_quietCnt <= r_quietCnt - Q_W'(1);
            if (w_spurious || (|w_lost))
                r_err <= 1'b1;
            r_tagValid[0] <= |w_rdGrant;
            r_tagPort[0]  <= w_rdPort;
            for (int s = 1; s < RD_LATENCY; s++) begin
                r_tagValid[s] <= r_tagValid[s-1];
                r_tagPort[s]  <= r_tagPort[s-1];
            end
            for (int j = 0; j < NUM_R; j++) begin
                r_credit[j] <= r_credit[j] + CR_W'(w_rdGrant[j]) - CR_W'(w_pop[j]) - CR_W'(w_lost[j]);
                r_count[j]  <= r_count[j] + CR_W'(w_push[j]) - CR_W'(w_pop[j]);
                if (w_push[j])
                    r_wrPtr[j] <= r_wrPtr[j] + PTR_W'(1);
                if (w_pop[j])
                    r_rdPtr[j] <= r_rdPtr[j] + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge sram_clock) begin
        for (int j = 0; j < NUM_R; j++)
            if (w_push[j])
                r_buf[j][r_wrPtr[j]] <= i_bus.sram_data_out;
    end
endmodule

// File: tb/tb_sram_arbiter_rr.sv
// Scoreboard bench for sram_arbiter_rr: a fixed-latency SRAM model feeds expected read data
// into per-port queues at grant time, and every consumer pop is checked against them.
module tb_sram_arbiter_rr;
    localparam int NW = 2, NR = 2, AW = 18, DW = 32, MW = 4, LAT = 3, DEPTH = 4;

    logic sram_clock = 1'b0;
    logic reset      = 1'b1;

    sram_arbiter_rr_if #(.NUM_W(NW), .NUM_R(NR), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

    sram_arbiter_rr #(
        .NUM_W(NW), .NUM_R(NR), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
        .RD_LATENCY(LAT), .RBUF_DEPTH(DEPTH)
    ) dut (
        .sram_clock(sram_clock),
        .reset(reset),
        .i_bus(bus)
    );

    always #5 sram_clock = ~sram_clock;

    logic [NW-1:0] wValid     = '0;
    logic [NR-1:0] rReqValid  = '0;
    logic [NR-1:0] rRespReady = '0;
    logic [AW-1:0] wAddr [NW];
    logic [DW-1:0] wData [NW];
    logic [MW-1:0] wMask [NW];
    logic [AW-1:0] rAddr [NR];
    logic          sramReady    = 1'b1;
    logic          dataOutValid = 1'b0;
    logic [DW-1:0] dataOut      = '0;
    bit            injectDv     = 1'b0;

    assign bus.w_valid             = wValid;
    assign bus.w_addr              = {wAddr[1], wAddr[0]};
    assign bus.w_data              = {wData[1], wData[0]};
    assign bus.w_mask              = {wMask[1], wMask[0]};
    assign bus.r_req_valid         = rReqValid;
    assign bus.r_addr              = {rAddr[1], rAddr[0]};
    assign bus.r_resp_ready        = rRespReady;
    assign bus.sram_ready          = sramReady;
    assign bus.sram_data_out       = dataOut;
    assign bus.sram_data_out_valid = dataOutValid;

    bit            pipeV [LAT+1];
    logic [DW-1:0] pipeD [LAT+1];
    logic [DW-1:0] expQ0 [$];
    logic [DW-1:0] expQ1 [$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   lastGrant = -1;
    logic lastAddrValid = 1'b0;

    function automatic logic [DW-1:0] readData(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - 18'h00010;
        return 32'hDEADBEEF ^ (32'(off) * 32'h9E3779B1);
    endfunction

    task automatic randomizeOperands();
        for (int i = 0; i < NW; i++) begin
            wAddr[i] = AW'($urandom);
            wData[i] = $urandom;
            wMask[i] = MW'($urandom_range(1, 15));
        end
        for (int j = 0; j < NR; j++)
            rAddr[j] = AW'($urandom);
    endtask

    // One clock: SRAM model drives returns at negedge, grant/pop observation at negedge+1,
    // then the caller gets control at posedge+1 to set the next cycle's inputs.
    task automatic stepCycle();
        int            nReady;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] got;
        logic [DW-1:0] want;
        @(negedge sram_clock);
        for (int k = LAT; k > 0; k--) begin
            pipeV[k] = pipeV[k-1];
            pipeD[k] = pipeD[k-1];
        end
        pipeV[0] = 1'b0;
        pipeD[0] = '0;
        dataOutValid = pipeV[LAT] | injectDv;
        dataOut      = pipeV[LAT] ? pipeD[LAT] : 32'h5A5A5A5A;
        #1;
        lastGrant = -1;
        nReady    = 0;
        for (int i = 0; i < NW; i++)
            if (bus.w_ready[i] === 1'b1) begin lastGrant = i; nReady++; end
        for (int j = 0; j < NR; j++)
            if (bus.r_req_ready[j] === 1'b1) begin lastGrant = NW + j; nReady++; end
        lastAddrValid = bus.sram_addr_valid;
        total++;
        if (nReady > 1 || bus.sram_addr_valid !== (nReady == 1)) begin
            bad++;
            $display("[TB] FAIL grant_onehot cyc=%0d: readies=%0d addr_valid=%b want at most one and matching valid", cyc, nReady, bus.sram_addr_valid);
        end
        if (lastGrant >= 0) begin
            total++;
            if ((lastGrant < NW) ? !wValid[lastGrant] : !rReqValid[lastGrant-NW]) begin
                bad++;
                $display("[TB] FAIL grant_idle_port cyc=%0d: granted %0d but its valid is 0", cyc, lastGrant);
            end
            expAddr = (lastGrant < NW) ? wAddr[lastGrant] : rAddr[lastGrant-NW];
            total++;
            if (bus.sram_addr !== expAddr) begin
                bad++;
                $display("[TB] FAIL sram_addr cyc=%0d: got %h want %h", cyc, bus.sram_addr, expAddr);
            end
            if (lastGrant < NW) begin
                total++;
                if (bus.sram_write_mask !== wMask[lastGrant] || bus.sram_data_in !== wData[lastGrant]) begin
                    bad++;
                    $display("[TB] FAIL write_cmd cyc=%0d: got mask %h data %h want mask %h data %h", cyc,
                             bus.sram_write_mask, bus.sram_data_in, wMask[lastGrant], wData[lastGrant]);
                end
            end else begin
                total++;
                if (bus.sram_write_mask !== '0) begin
                    bad++;
                    $display("[TB] FAIL read_mask cyc=%0d: got %h want 0", cyc, bus.sram_write_mask);
                end
                pipeV[0] = 1'b1;
                pipeD[0] = readData(bus.sram_addr);
                if (lastGrant == NW) expQ0.push_back(readData(rAddr[0]));
                else                 expQ1.push_back(readData(rAddr[1]));
            end
        end
        for (int p = 0; p < NR; p++) begin
            if (bus.r_resp_valid[p] === 1'b1 && rRespReady[p]) begin
                got = bus.r_resp_data[p*DW +: DW];
                total++;
                if ((p == 0 && expQ0.size() == 0) || (p == 1 && expQ1.size() == 0)) begin
                    bad++;
                    $display("[TB] FAIL resp_unexpected port %0d cyc=%0d: got %h want nothing", p, cyc, got);
                end else begin
                    if (p == 0) want = expQ0.pop_front();
                    else        want = expQ1.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("[TB] FAIL resp_data port %0d cyc=%0d: got %h want %h", p, cyc, got, want);
                    end
                end
            end
        end
        @(posedge sram_clock);
        #1;
        cyc++;
        randomizeOperands();
    endtask

    task automatic applyReset(input int n);
        reset      = 1'b1;
        rRespReady = '0;
        wValid     = '0;
        rReqValid  = '0;
        expQ0.delete();
        expQ1.delete();
        repeat (n) stepCycle();
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        wValid     = '0;
        rReqValid  = '0;
        rRespReady = '1;
        repeat (n) stepCycle();
        total++;
        if (expQ0.size() != 0 || expQ1.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain_pending: got %0d/%0d outstanding want 0/0", expQ0.size(), expQ1.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stepCycle();
        wValid = '1; rReqValid = '1; rRespReady = '1; sramReady = 1'b1;
        repeat (2) begin
            total++;
            if ({bus.w_ready, bus.r_req_ready, bus.r_resp_valid, bus.sram_addr_valid, bus.err} !== '0) begin
                bad++;
                $display("[TB] FAIL reset_ctrl: got %b want 0", {bus.w_ready, bus.r_req_ready, bus.r_resp_valid, bus.sram_addr_valid, bus.err});
            end
            total++;
            if ({bus.sram_addr, bus.sram_data_in, bus.sram_write_mask, bus.r_resp_data} !== '0) begin
                bad++;
                $display("[TB] FAIL reset_bus: got addr %h din %h mask %h want 0", bus.sram_addr, bus.sram_data_in, bus.sram_write_mask);
            end
            stepCycle();
        end
        reset = 1'b0;
        stepCycle();
        total++;
        if (lastGrant != 0) begin
            bad++;
            $display("[TB] FAIL reset_first_grant: got %0d want 0", lastGrant);
        end
        drain(8);
    endtask

    task automatic test_fairness();
        int grants [NW+NR];
        applyReset(2);
        foreach (grants[i]) grants[i] = 0;
        wValid = '1; rReqValid = '1; rRespReady = '1;
        for (int k = 0; k < 100; k++) begin
            stepCycle();
            total++;
            if (lastGrant != k % 4) begin
                bad++;
                $display("[TB] FAIL fair_order cycle %0d: got %0d want %0d", k, lastGrant, k % 4);
            end
            if (lastGrant >= 0) grants[lastGrant]++;
        end
        for (int i = 0; i < NW + NR; i++) begin
            total++;
            if (grants[i] != 25) begin
                bad++;
                $display("[TB] FAIL fair_count port %0d: got %0d want 25", i, grants[i]);
            end
        end
        drain(10);
        total++;
        if (bus.err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fair_err: got %b want 0", bus.err);
        end
    endtask

    task automatic test_latency();
        applyReset(2);
        rReqValid  = 2'b01;
        rAddr[0]   = 18'h00010;
        rRespReady = 2'b10;
        stepCycle();
        total++;
        if (lastGrant != NW) begin
            bad++;
            $display("[TB] FAIL lat_grant: got %0d want %0d", lastGrant, NW);
        end
        rReqValid = '0;
        for (int k = 1; k <= LAT; k++) begin
            total++;
            if (bus.r_resp_valid !== 2'b00) begin
                bad++;
                $display("[TB] FAIL lat_early t+%0d: got %b want 00", k, bus.r_resp_valid);
            end
            stepCycle();
        end
        total++;
        if (bus.r_resp_valid !== 2'b01 || bus.r_resp_data[DW-1:0] !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL lat_return: got valid %b data %h want 01 deadbeef", bus.r_resp_valid, bus.r_resp_data[DW-1:0]);
        end
        rRespReady = 2'b11;
        stepCycle();
        total++;
        if (bus.r_resp_valid !== 2'b00) begin
            bad++;
            $display("[TB] FAIL lat_pop: got %b want 00", bus.r_resp_valid);
        end
        drain(4);
    endtask

    task automatic test_backpressure();
        int r0Grants;
        int w0Grants;
        bit regranted;
        applyReset(2);
        r0Grants = 0;
        w0Grants = 0;
        wValid = 2'b01; rReqValid = 2'b01; rRespReady = 2'b00;
        for (int k = 0; k < 16; k++) begin
            stepCycle();
            if (lastGrant == NW) r0Grants++;
            if (lastGrant == 0)  w0Grants++;
        end
        total++;
        if (r0Grants != DEPTH) begin
            bad++;
            $display("[TB] FAIL bp_r0_grants: got %0d want %0d", r0Grants, DEPTH);
        end
        total++;
        if (w0Grants != 12) begin
            bad++;
            $display("[TB] FAIL bp_w0_grants: got %0d want 12", w0Grants);
        end
        total++;
        if (bus.r_req_ready[0] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_ready_blocked: got %b want 0", bus.r_req_ready[0]);
        end
        rRespReady = 2'b01;
        stepCycle();
        rRespReady = 2'b00;
        regranted = 1'b0;
        for (int k = 0; k < NW + NR && !regranted; k++) begin
            stepCycle();
            if (lastGrant == NW) regranted = 1'b1;
        end
        total++;
        if (!regranted) begin
            bad++;
            $display("[TB] FAIL bp_regrant: got no R0 grant in %0d cycles want one", NW + NR);
        end
        drain(12);
    endtask

    task automatic test_stall();
        applyReset(2);
        wValid = '1; rReqValid = '1; rRespReady = '1;
        stepCycle();
        stepCycle();
        sramReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            total++;
            if (lastGrant != -1 || lastAddrValid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_grant cycle %0d: got grant %0d valid %b want none", k, lastGrant, lastAddrValid);
            end
        end
        sramReady = 1'b1;
        stepCycle();
        total++;
        if (lastGrant != NW) begin
            bad++;
            $display("[TB] FAIL stall_resume: got %0d want %0d", lastGrant, NW);
        end
        drain(10);
        total++;
        if (bus.err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_err: got %b want 0", bus.err);
        end
    endtask

    task automatic test_error_recovery();
        int r0Grants;
        applyReset(2);
        rRespReady = '1;
        repeat (LAT + 1) stepCycle();
        injectDv = 1'b1;
        stepCycle();
        injectDv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.err !== 1'b1 || bus.r_resp_valid !== 2'b00) begin
                bad++;
                $display("[TB] FAIL err_sticky t+%0d: got err %b resp_valid %b want 1 00", k + 1, bus.err, bus.r_resp_valid);
            end
            stepCycle();
        end
        rReqValid = 2'b01;
        stepCycle();
        rReqValid = 2'b10;
        stepCycle();
        total++;
        if (lastGrant != NW + 1) begin
            bad++;
            $display("[TB] FAIL rec_inflight: got %0d want %0d", lastGrant, NW + 1);
        end
        applyReset(2);
        rRespReady = '1;
        for (int k = 0; k < 6; k++) begin
            total++;
            if (bus.err !== 1'b0 || bus.r_resp_valid !== 2'b00) begin
                bad++;
                $display("[TB] FAIL rec_ignored t+%0d: got err %b resp_valid %b want 0 00", k, bus.err, bus.r_resp_valid);
            end
            stepCycle();
        end
        r0Grants   = 0;
        rReqValid  = 2'b01;
        rRespReady = 2'b00;
        for (int k = 0; k < 8; k++) begin
            stepCycle();
            if (lastGrant == NW) r0Grants++;
        end
        total++;
        if (r0Grants != DEPTH) begin
            bad++;
            $display("[TB] FAIL rec_credits: got %0d R0 grants want %0d", r0Grants, DEPTH);
        end
        drain(12);
    endtask

    initial begin
        foreach (pipeV[k]) begin
            pipeV[k] = 1'b0;
            pipeD[k] = '0;
        end
        randomizeOperands();
        $display("[TB] sram_arbiter_rr bench start");
        test_reset();
        test_fairness();
        test_latency();
        test_backpressure();
        test_stall();
        test_error_recovery();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
